// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serializer; txd_o falls one cycle after a write into an idle, empty block.
// No backpressure: writes while full are dropped and latch tx_overflow; queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int BAUD_RATE  = 9_600,
    parameter int CLOCK_RATE = 40_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_fifo_din,
    input  logic                          tx_fifo_wr_en,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
    output logic                          tx_overflow,
    output logic                          tx_busy,
    output logic                          txd_o
);

    localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic          r_txd;
    logic          r_busy;

    logic          w_wr;
    logic          w_pop;
    logic          w_has_data;
    logic          w_tc;
    logic [7:0]    w_head;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_shift_nxt;
    logic [CW-1:0] w_baud_nxt;
    logic [2:0]    w_idx_nxt;
    logic          w_txd_nxt;

    // Full flag sampled before the edge gates the write, even when a pop frees a slot on the same edge.
    assign w_wr        = tx_fifo_wr_en & ~r_full;
    assign w_has_data  = (r_count != '0);
    assign w_tc        = (r_baud_cnt == CW'(BAUD_DIV - 1));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= tx_fifo_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (tx_fifo_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_has_data) w_state_nxt = S_START;
            S_START: if (w_tc) w_state_nxt = S_DATA;
            S_DATA:  if (w_tc && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (w_tc) w_state_nxt = w_has_data ? S_START : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud_cnt + CW'(1);
        w_idx_nxt   = r_bit_idx;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_txd_nxt  = 1'b1;
                if (w_has_data) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_tc) begin
                    w_baud_nxt = '0;
                    w_idx_nxt  = '0;
                    w_txd_nxt  = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_txd_nxt = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_txd_nxt   = r_shift[1];
                        w_idx_nxt   = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tc) begin
                    w_baud_nxt = '0;
                    w_txd_nxt  = 1'b1;
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (w_has_data) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_txd_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_baud_nxt = '0;
                w_txd_nxt  = 1'b1;
            end
        endcase
    end

    assign tx_fifo_full  = r_full;
    assign tx_fifo_empty = r_empty;
    assign tx_fifo_count = r_count;
    assign tx_overflow   = r_overflow;
    assign tx_busy       = r_busy;
    assign txd_o         = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-level queue model plus a line-decoding monitor.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       wr_en = 1'b0;
    logic       full, empty, ovf, busy, txd;
    logic [2:0] count;

    uart_tx_fifo #(.BAUD_RATE(10), .CLOCK_RATE(160), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_fifo_din   (din),
        .tx_fifo_wr_en (wr_en),
        .tx_fifo_full  (full),
        .tx_fifo_empty (empty),
        .tx_fifo_count (count),
        .tx_overflow   (ovf),
        .tx_busy       (busy),
        .txd_o         (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the position inside the frame currently on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_k    = 0;
    logic [7:0] m_cur  = 8'h00;

    always @(posedge clk or negedge rst_n) begin : model
        bit fb;
        if (!rst_n) begin
            m_q.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_k    = 0;
        end else begin
            fb = (m_q.size() == DEPTH);
            if (!m_busy) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_sent.push_back(m_cur);
                    m_busy = 1'b1;
                    m_k    = 0;
                end
            end else begin
                m_k++;
                if (m_k == FRAME) begin
                    m_k = 0;
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_sent.push_back(m_cur);
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
            if (wr_en) begin
                if (fb) m_ovf = 1'b1;
                else    m_q.push_back(din);
            end
        end
    end

    function automatic logic exp_txd();
        int p;
        if (!m_busy) return 1'b1;
        p = m_k / BD;
        if (p == 0) return 1'b0;
        if (p <= 8) return m_cur[p-1];
        return 1'b1;
    endfunction

    bit chk_en = 1'b0;
    int peak   = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd",   txd,   exp_txd());
            check("busy",  busy,  m_busy);
            check("count", count, m_q.size());
            check("full",  full,  m_q.size() == DEPTH);
            check("empty", empty, m_q.size() == 0);
            check("ovf",   ovf,   m_ovf);
            if (int'(count) > peak) peak = int'(count);
        end
    end

    // Line monitor: start on the first low sample, sample each bit mid-cell.
    logic [7:0] mon_got[$];
    int         mon_k = -1;
    logic [7:0] mon_b = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_k = -1;
        end else if (mon_k < 0) begin
            if (txd == 1'b0) mon_k = 0;
        end else begin
            mon_k++;
            if (mon_k % BD == BD / 2 && mon_k / BD >= 1 && mon_k / BD <= 8)
                mon_b[mon_k / BD - 1] = txd;
            if (mon_k == FRAME - 1) begin
                mon_got.push_back(mon_b);
                mon_k = -1;
            end
        end
    end

    int mon_base  = 0;
    int sent_base = 0;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        din   = b;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_k(input int k);
        int n = 0;
        while (!(m_busy && m_k == k) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("wait_k_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((m_busy || m_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) check("drain_timeout", 0, 1);
        idle(3);
    endtask

    task automatic check_mon(input string tag);
        int ng = mon_got.size() - mon_base;
        int ne = m_sent.size() - sent_base;
        check({tag, "_nbytes"}, ng, ne);
        for (int i = 0; i < ne && i < ng; i++)
            check({tag, "_byte"}, mon_got[mon_base + i], m_sent[sent_base + i]);
        mon_base  = mon_got.size();
        sent_base = m_sent.size();
    endtask

    logic [7:0] b5_last;

    initial begin
        // Reset with random inputs toggling.
        repeat (8) begin
            @(posedge clk);
            #1;
            din   = 8'($urandom);
            wr_en = 1'($urandom_range(0, 1));
        end
        check("rst_txd",   txd,   1);
        check("rst_busy",  busy,  0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_count", count, 0);
        check("rst_ovf",   ovf,   0);
        wr_en  = 1'b0;
        chk_en = 1'b1;
        rst_n  = 1'b1;
        idle(200);

        // Single byte.
        push(8'hA5);
        check("s2_count1", count, 1);
        idle(1);
        check("s2_count0", count, 0);
        check("s2_start",  txd,   0);
        wait_drain();
        check("s2_decode", mon_got[mon_base], 8'hA5);
        check_mon("s2");

        // Back-to-back frames.
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_drain();
        check("s3_b0", mon_got[mon_base],     8'h00);
        check("s3_b1", mon_got[mon_base + 1], 8'hFF);
        check("s3_b2", mon_got[mon_base + 2], 8'h3C);
        check_mon("s3");

        // Overflow, including a write dropped on a STOP-to-START pop edge.
        peak = 0;
        push(8'h99);
        idle(5);
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        check("s4_full", full, 1);
        check("s4_ovf",  ovf,  1);
        wait_k(FRAME - 1);
        push(8'h77);
        check("s4_count_after_pop", count, 3);
        wait_drain();
        check("s4_peak", peak, 4);
        check("s4_b0", mon_got[mon_base],     8'h99);
        check("s4_b1", mon_got[mon_base + 1], 8'h10);
        check("s4_b4", mon_got[mon_base + 4], 8'h13);
        check("s4_nbytes_literal", mon_got.size() - mon_base, 5);
        check_mon("s4");

        // Simultaneous write and pop at count=2.
        push(8'($urandom));
        push(8'($urandom));
        push(8'($urandom));
        check("s5_count_pre", count, 2);
        wait_k(FRAME - 1);
        b5_last = 8'($urandom);
        push(b5_last);
        check("s5_count_hold", count, 2);
        wait_drain();
        check("s5_last", mon_got[mon_base + 3], b5_last);
        check_mon("s5");

        // Reset mid-frame with three bytes queued.
        for (int i = 0; i < 4; i++) push(8'($urandom));
        check("s6_count_pre", count, 3);
        wait_k(70);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_txd_async",   txd,   1);
        check("s6_count_async", count, 0);
        check("s6_busy_async",  busy,  0);
        idle(2);
        rst_n     = 1'b1;
        mon_base  = mon_got.size();
        sent_base = m_sent.size();
        idle(1);
        push(8'h55);
        wait_drain();
        check("s6_decode", mon_got[mon_base], 8'h55);
        check_mon("s6");

        // Random soak.
        repeat (1500) begin
            wr_en = ($urandom_range(0, 99) < 8);
            din   = 8'($urandom);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_drain();
        check_mon("soak");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
